// File: rtl/lpc_tpm_periph.sv
// LPC I/O-cycle target that forwards byte accesses to the TwPM register block.
// Optional continuous-mode SERIRQ is built in when LPC_SERIRQ_EN is defined.
module lpc_tpm_periph (
    input  logic        clk_i,
    input  logic        nrst_i,
    input  logic        lframe_i,
    inout  wire  [3:0]  lad_bus,
    inout  wire         serirq,
    input  logic [7:0]  lpc_data_i,
    output logic [7:0]  lpc_data_o,
    output logic [15:0] lpc_addr_o,
    output logic        lpc_data_wr,
    input  logic        lpc_wr_done,
    input  logic        lpc_data_rd,
    output logic        lpc_data_req,
    input  logic [3:0]  irq_num,
    input  logic        interrupt
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CYCDIR,
        ST_ADDR,
        ST_WDATA,
        ST_TAR_H,
        ST_SYNC,
        ST_RDATA,
        ST_TAR_P
    } state_t;

    state_t      state_reg, state_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        write_reg, write_next;
    logic [15:0] addr_reg, addr_next;
    logic [7:0]  wdata_reg, wdata_next;
    logic [7:0]  rdata_reg, rdata_next;
    logic        wr_reg, wr_next;
    logic        req_reg, req_next;

    logic [3:0]  lad_in;
    logic [3:0]  lad_out;
    logic        lad_oe;
    logic        sync_ack;

    assign lad_in   = lad_bus;
    assign sync_ack = write_reg ? lpc_wr_done : lpc_data_rd;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 2'd0;
            write_reg <= 1'b0;
            addr_reg  <= 16'h0000;
            wdata_reg <= 8'h00;
            rdata_reg <= 8'h00;
            wr_reg    <= 1'b0;
            req_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            write_reg <= write_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            rdata_reg <= rdata_next;
            wr_reg    <= wr_next;
            req_reg   <= req_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        write_next = write_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        rdata_next = rdata_reg;
        wr_next    = wr_reg;
        req_next   = req_reg;

        // LFRAME# low always wins: it either starts a new cycle or aborts the current one.
        if (!lframe_i) begin
            state_next = (lad_in == 4'h0) ? ST_CYCDIR : ST_IDLE;
            cnt_next   = 2'd0;
            wr_next    = 1'b0;
            req_next   = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                end
                ST_CYCDIR: begin
                    cnt_next = 2'd0;
                    if (lad_in == 4'h0) begin
                        write_next = 1'b0;
                        state_next = ST_ADDR;
                    end else if (lad_in == 4'h2) begin
                        write_next = 1'b1;
                        state_next = ST_ADDR;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    addr_next = {addr_reg[11:0], lad_in};
                    cnt_next  = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = write_reg ? ST_WDATA : ST_TAR_H;
                    end
                end
                ST_WDATA: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd0) begin
                        wdata_next[3:0] = lad_in;
                    end else begin
                        wdata_next[7:4] = lad_in;
                        cnt_next        = 2'd0;
                        state_next      = ST_TAR_H;
                    end
                end
                ST_TAR_H: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd1) begin
                        cnt_next   = 2'd0;
                        wr_next    = write_reg;
                        req_next   = !write_reg;
                        state_next = ST_SYNC;
                    end
                end
                ST_SYNC: begin
                    if (sync_ack) begin
                        wr_next    = 1'b0;
                        req_next   = 1'b0;
                        cnt_next   = 2'd0;
                        state_next = write_reg ? ST_TAR_P : ST_RDATA;
                        if (!write_reg) begin
                            rdata_next = lpc_data_i;
                        end
                    end
                end
                ST_RDATA: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd1) begin
                        cnt_next   = 2'd0;
                        state_next = ST_TAR_P;
                    end
                end
                ST_TAR_P: begin
                    cnt_next = cnt_reg + 2'd1;
                    if (cnt_reg == 2'd1) begin
                        cnt_next   = 2'd0;
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = 2'd0;
                end
            endcase
        end
    end

    // The ready sync follows the acknowledge combinationally so a zero-wait answer
    // is reported on the very first SYNC clock.
    always_comb begin
        lad_oe  = 1'b0;
        lad_out = 4'h0;
        if (lframe_i) begin
            case (state_reg)
                ST_SYNC: begin
                    lad_oe  = 1'b1;
                    lad_out = sync_ack ? 4'b0000 : 4'b0110;
                end
                ST_RDATA: begin
                    lad_oe  = 1'b1;
                    lad_out = (cnt_reg == 2'd0) ? rdata_reg[3:0] : rdata_reg[7:4];
                end
                ST_TAR_P: begin
                    if (cnt_reg == 2'd0) begin
                        lad_oe  = 1'b1;
                        lad_out = 4'hF;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign lad_bus      = lad_oe ? lad_out : 4'bzzzz;
    assign lpc_addr_o   = addr_reg;
    assign lpc_data_o   = wdata_reg;
    assign lpc_data_wr  = wr_reg;
    assign lpc_data_req = req_reg;

`ifdef LPC_SERIRQ_EN
    logic [3:0] low_cnt_reg;
    logic       sirq_active_reg;
    logic [3:0] slot_reg;
    logic [1:0] phase_reg;
    logic       irq_hit;

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            low_cnt_reg     <= 4'd0;
            sirq_active_reg <= 1'b0;
            slot_reg        <= 4'd0;
            phase_reg       <= 2'd0;
        end else if (sirq_active_reg) begin
            low_cnt_reg <= 4'd0;
            if (phase_reg == 2'd2) begin
                phase_reg <= 2'd0;
                slot_reg  <= slot_reg + 4'd1;
                if (slot_reg == 4'd15) begin
                    sirq_active_reg <= 1'b0;
                end
            end else begin
                phase_reg <= phase_reg + 2'd1;
            end
        end else if (serirq == 1'b0) begin
            if (low_cnt_reg != 4'hF) begin
                low_cnt_reg <= low_cnt_reg + 4'd1;
            end
        end else begin
            // A 4..8 clock low pulse is a host start frame; slot 0 starts right after.
            if (low_cnt_reg >= 4'd4 && low_cnt_reg <= 4'd8) begin
                sirq_active_reg <= 1'b1;
                slot_reg        <= 4'd0;
                phase_reg       <= 2'd0;
            end
            low_cnt_reg <= 4'd0;
        end
    end

    assign irq_hit = sirq_active_reg && (slot_reg == irq_num) && !interrupt;
    assign serirq  = (irq_hit && phase_reg == 2'd0) ? 1'b0 :
                     (irq_hit && phase_reg == 2'd1) ? 1'b1 : 1'bz;
`else
    logic unused_sirq;
    assign unused_sirq = ^{irq_num, interrupt, serirq};
    assign serirq      = 1'bz;
`endif

endmodule

// File: tb/tb_lpc_tpm_periph.sv
// Scoreboard bench for lpc_tpm_periph: LPC host model, register-block responder,
// and SERIRQ start-frame generator. LAD is pulled low, so a released bus reads 0.
`timescale 1ns/1ps
module tb_lpc_tpm_periph;

    localparam logic [3:0] LAD_FLOAT = 4'h0;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        lframe = 1'b1;
    logic        host_oe = 1'b0;
    logic [3:0]  host_lad = 4'h0;
    logic        host_irq_low = 1'b0;
    logic [7:0]  lpc_data_i = 8'h00;
    logic        lpc_wr_done = 1'b0;
    logic        lpc_data_rd = 1'b0;
    logic [3:0]  irq_num = 4'd3;
    logic        interrupt = 1'b1;
    logic [7:0]  lpc_data_o;
    logic [15:0] lpc_addr_o;
    logic        lpc_data_wr;
    logic        lpc_data_req;
    wire  [3:0]  lad_bus;
    wire         serirq;

    assign lad_bus = host_oe ? host_lad : 4'bzzzz;
    assign serirq  = host_irq_low ? 1'b0 : 1'bz;
    pulldown (lad_bus);
    pullup (serirq);

    always #5 clk = ~clk;

    lpc_tpm_periph dut (
        .clk_i        (clk),
        .nrst_i       (nrst),
        .lframe_i     (lframe),
        .lad_bus      (lad_bus),
        .serirq       (serirq),
        .lpc_data_i   (lpc_data_i),
        .lpc_data_o   (lpc_data_o),
        .lpc_addr_o   (lpc_addr_o),
        .lpc_data_wr  (lpc_data_wr),
        .lpc_wr_done  (lpc_wr_done),
        .lpc_data_rd  (lpc_data_rd),
        .lpc_data_req (lpc_data_req),
        .irq_num      (irq_num),
        .interrupt    (interrupt)
    );

    typedef struct {
        string       tag;
        logic [15:0] val;
    } item_t;

    item_t exp_q[$];
    item_t obs_q[$];
    int    checks = 0;
    int    errors = 0;

    function automatic void exp_push(input string tag, input logic [15:0] v);
        item_t it;
        it.tag = tag;
        it.val = v;
        exp_q.push_back(it);
    endfunction

    function automatic void obs_push(input string tag, input logic [15:0] v);
        item_t it;
        it.tag = tag;
        it.val = v;
        obs_q.push_back(it);
    endfunction

    task automatic drive(input logic lf, input logic oe, input logic [3:0] nib);
        @(posedge clk);
        #1;
        lframe   = lf;
        host_oe  = oe;
        host_lad = nib;
    endtask

    task automatic next_period();
        @(posedge clk);
        #1;
        @(negedge clk);
    endtask

    // One complete host cycle; expectations are queued up front from the
    // transaction itself, observations are queued as the DUT answers.
    task automatic lpc_cycle(input logic [3:0] start, input logic [3:0] cyc,
                             input logic [15:0] addr, input logic [7:0] data,
                             input int waits);
        logic valid;
        logic wr;
        valid = nrst && (start == 4'h0) && (cyc == 4'h0 || cyc == 4'h2);
        wr    = (cyc == 4'h2);

        if (valid || !nrst) exp_push("addr", valid ? addr : 16'h0000);
        exp_push("tar2_lad", {12'h000, LAD_FLOAT});
        for (int s = 0; s <= waits; s++) begin
            exp_push("sync_lad", {12'h000, !valid ? LAD_FLOAT : ((s == waits) ? 4'h0 : 4'h6)});
            exp_push("sync_strobes", {14'h0, !valid ? 2'b00 : (wr ? 2'b10 : 2'b01)});
        end
        if (!wr) begin
            exp_push("rdata_lo", {12'h000, valid ? data[3:0] : LAD_FLOAT});
            exp_push("rdata_hi", {12'h000, valid ? data[7:4] : LAD_FLOAT});
        end
        if (wr && valid) exp_push("wdata", {8'h00, data});
        exp_push("tarp1_lad", {12'h000, valid ? 4'hF : LAD_FLOAT});
        exp_push("tarp1_strobes", 16'h0000);
        exp_push("tarp2_lad", {12'h000, LAD_FLOAT});

        drive(1'b0, 1'b1, start);
        drive(1'b1, 1'b1, cyc);
        for (int i = 3; i >= 0; i--) drive(1'b1, 1'b1, addr[i*4 +: 4]);
        if (wr) begin
            drive(1'b1, 1'b1, data[3:0]);
            drive(1'b1, 1'b1, data[7:4]);
        end
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b1, 1'b0, 4'h0);
        @(negedge clk);
        if (valid || !nrst) obs_push("addr", lpc_addr_o);
        obs_push("tar2_lad", {12'h000, lad_bus});
        for (int s = 0; s <= waits; s++) begin
            @(posedge clk);
            #1;
            if (wr) lpc_wr_done = (s == waits);
            else    lpc_data_rd = (s == waits);
            lpc_data_i = (s == waits) ? data : 8'h00;
            @(negedge clk);
            obs_push("sync_lad", {12'h000, lad_bus});
            obs_push("sync_strobes", {14'h0, lpc_data_wr, lpc_data_req});
        end
        @(posedge clk);
        #1;
        lpc_wr_done = 1'b0;
        lpc_data_rd = 1'b0;
        lpc_data_i  = 8'hFF;
        if (!wr) begin
            @(negedge clk);
            obs_push("rdata_lo", {12'h000, lad_bus});
            next_period();
            obs_push("rdata_hi", {12'h000, lad_bus});
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        if (wr && valid) obs_push("wdata", {8'h00, lpc_data_o});
        obs_push("tarp1_lad", {12'h000, lad_bus});
        obs_push("tarp1_strobes", {14'h0, lpc_data_wr, lpc_data_req});
        next_period();
        obs_push("tarp2_lad", {12'h000, lad_bus});
    endtask

    task automatic test_reset();
        item_t e, o;
        @(negedge clk);
        exp_push("rst_addr", 16'h0000);      obs_push("rst_addr", lpc_addr_o);
        exp_push("rst_wdata", 16'h0000);     obs_push("rst_wdata", {8'h00, lpc_data_o});
        exp_push("rst_strobes", 16'h0000);   obs_push("rst_strobes", {14'h0, lpc_data_wr, lpc_data_req});
        exp_push("rst_lad", {12'h000, LAD_FLOAT}); obs_push("rst_lad", {12'h000, lad_bus});
        exp_push("rst_serirq", 16'h0001);    obs_push("rst_serirq", {15'h0, serirq});
        lpc_cycle(4'h0, 4'h0, 16'h0012, 8'hA5, 1);
        lpc_cycle(4'h0, 4'h2, 16'h0034, 8'h5A, 1);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        // Start a read, then pull reset in the middle of its SYNC phase.
        drive(1'b0, 1'b1, 4'h0);
        drive(1'b1, 1'b1, 4'h0);
        drive(1'b1, 1'b1, 4'h1);
        drive(1'b1, 1'b1, 4'h2);
        drive(1'b1, 1'b1, 4'h3);
        drive(1'b1, 1'b1, 4'h4);
        drive(1'b1, 1'b1, 4'hF);
        drive(1'b1, 1'b0, 4'h0);
        next_period();
        exp_push("mid_sync_lad", 16'h0006);  obs_push("mid_sync_lad", {12'h000, lad_bus});
        exp_push("mid_sync_req", 16'h0001);  obs_push("mid_sync_req", {15'h0, lpc_data_req});
        nrst = 1'b0;
        #1;
        exp_push("async_rst_lad", {12'h000, LAD_FLOAT}); obs_push("async_rst_lad", {12'h000, lad_bus});
        exp_push("async_rst_req", 16'h0000); obs_push("async_rst_req", {15'h0, lpc_data_req});
        exp_push("async_rst_addr", 16'h0000); obs_push("async_rst_addr", lpc_addr_o);
        @(posedge clk);
        #1;
        nrst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp_push("post_rst_lad", {12'h000, LAD_FLOAT}); obs_push("post_rst_lad", {12'h000, lad_bus});
            @(posedge clk);
            #1;
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.val !== e.val) begin
                errors++;
                $display("FAIL reset %s: got %h, expected %h", e.tag, o.val, e.val);
            end
        end
    endtask

    task automatic test_read();
        item_t e, o;
        logic [15:0] addrs [4] = '{16'h0000, 16'h0013, 16'h0055, 16'h007F};
        for (int t = 0; t < 4; t++) begin
            lpc_cycle(4'h0, 4'h0, addrs[t], 8'hA5, t);
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.val !== e.val) begin
                    errors++;
                    $display("FAIL read@%h %s: got %h, expected %h", addrs[t], e.tag, o.val, e.val);
                end
            end
            $display("read  addr=%h waits=%0d done", addrs[t], t);
        end
    endtask

    task automatic test_write();
        item_t e, o;
        lpc_cycle(4'h0, 4'h2, 16'h0024, 8'h3C, 3);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.val !== e.val) begin
                errors++;
                $display("FAIL write %s: got %h, expected %h", e.tag, o.val, e.val);
            end
        end
        $display("write addr=0024 data=3c waits=3 done");
    endtask

    task automatic test_bad_cycle();
        item_t e, o;
        lpc_cycle(4'h5, 4'h0, 16'h0030, 8'hA5, 1);
        lpc_cycle(4'h0, 4'h4, 16'h0030, 8'hA5, 1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.val !== e.val) begin
                errors++;
                $display("FAIL bad_cycle %s: got %h, expected %h", e.tag, o.val, e.val);
            end
        end
        $display("bad cycles (start 5, cycdir 4) done");
    endtask

    task automatic test_abort();
        item_t e, o;
        drive(1'b0, 1'b1, 4'h0);
        drive(1'b1, 1'b1, 4'h0);
        drive(1'b1, 1'b1, 4'h0);
        drive(1'b1, 1'b1, 4'h0);
        drive(1'b0, 1'b1, 4'hF);
        drive(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 6; i++) begin
            exp_push("abort_lad", {12'h000, LAD_FLOAT});
            exp_push("abort_strobes", 16'h0000);
            @(negedge clk);
            obs_push("abort_lad", {12'h000, lad_bus});
            obs_push("abort_strobes", {14'h0, lpc_data_wr, lpc_data_req});
            @(posedge clk);
            #1;
        end
        lpc_cycle(4'h0, 4'h0, 16'h0042, 8'h96, 1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.val !== e.val) begin
                errors++;
                $display("FAIL abort %s: got %h, expected %h", e.tag, o.val, e.val);
            end
        end
        $display("abort then read addr=0042 done");
    endtask

    task automatic test_back_to_back();
        item_t e, o;
        lpc_cycle(4'h0, 4'h2, 16'h0010, 8'h81, 0);
        lpc_cycle(4'h0, 4'h0, 16'h0011, 8'h7E, 2);
        lpc_cycle(4'h0, 4'h2, 16'hFFFF, 8'hC3, 1);
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.val !== e.val) begin
                errors++;
                $display("FAIL back_to_back %s: got %h, expected %h", e.tag, o.val, e.val);
            end
        end
        $display("back-to-back write/read/write done");
    endtask

    task automatic test_serirq();
        item_t e, o;
        logic exp_bit;
        for (int pass = 0; pass < 2; pass++) begin
            @(posedge clk);
            #1;
            irq_num      = 4'd3;
            interrupt    = (pass == 1);
            host_irq_low = 1'b1;
            repeat (6) @(posedge clk);
            #1;
            host_irq_low = 1'b0;
            for (int p = 1; p <= 20; p++) begin
                // Slot 0 sample clock is one period after the host releases the line.
`ifdef LPC_SERIRQ_EN
                exp_bit = !((pass == 0) && (p == 10));
`else
                exp_bit = 1'b1;
`endif
                exp_push($sformatf("serirq_p%0d", p), {15'h0, exp_bit});
                next_period();
                obs_push($sformatf("serirq_p%0d", p), {15'h0, serirq});
            end
            repeat (40) @(posedge clk);
            while (exp_q.size() > 0 && obs_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                checks++;
                if (o.val !== e.val) begin
                    errors++;
                    $display("FAIL serirq pass%0d %s: got %h, expected %h", pass, e.tag, o.val, e.val);
                end
            end
            $display("serirq pass=%0d interrupt=%0d done", pass, interrupt);
        end
        interrupt = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_read();
        test_write();
        test_bad_cycle();
        test_abort();
        test_back_to_back();
        test_serirq();
        if (exp_q.size() != 0 || obs_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d/%0d entries, expected 0/0", exp_q.size(), obs_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
